mux_scan_sequencer: RTL and testbench
=====================================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter LAST_SEL, default 3'd7, is the final select value of a scan; legal values are 0..7.
REQ-002 Parameter RESET_VAL, default 4'h0, is the reset value of all eight data registers.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 wr_en  input  1  is the data-register write strobe.
REQ-006 wr_addr  input  3  selects the register to write: 0=a … 7=h.
REQ-007 wr_data  input  4  is the write data.
REQ-008 start  input  1  is the scan request, sampled in IDLE only.
REQ-009 hold  input  1  pauses the scan when high.
REQ-010 a,b,c,d,e,f,g,h  output  4 each  carry the registered data; each output is a direct register output that feeds the 4-bit 8:1 mux data inputs.
REQ-011 s  output  3  is the registered select that feeds the mux select.
REQ-012 valid  output  1  indicates that s addresses a channel belonging to the current scan.
REQ-013 busy  output  1  is high while in SCAN or DONE.
REQ-014 done  output  1  is a one-cycle pulse at scan completion.

Function
REQ-015 Register bank: on a clock edge with wr_en=1, the register at wr_addr SHALL load wr_data; the new value is visible on its output the next cycle; writes are accepted in every state.
REQ-016 FSM states SHALL be IDLE, SCAN and DONE, with an encoding chosen freely.
REQ-017 IDLE: s=0, valid=0, busy=0, done=0; start=1 SHALL move the FSM to SCAN with s=0 on the next cycle.
REQ-018 SCAN: valid=1, busy=1; each edge with hold=0 SHALL advance s by 1; each edge with hold=1 SHALL keep s and remain in SCAN.
REQ-019 SCAN with s==LAST_SEL and hold=0: the next state SHALL be DONE, with s=0 and valid=0.
REQ-020 DONE: done=1 and busy=1 for exactly one cycle, then the FSM SHALL go to IDLE unconditionally; hold is ignored in DONE.
REQ-021 With LAST_SEL=0, a scan SHALL last exactly one SCAN cycle at s=0.
REQ-022 A start input while busy=1 SHALL be ignored and not queued.
REQ-023 A start held high continuously SHALL produce back-to-back scans separated by a single IDLE cycle.
REQ-024 s SHALL never exceed LAST_SEL and SHALL never wrap from 7 to 0 within SCAN.
REQ-025 A write to the register addressed by s in the same cycle: the mux input SHALL show the old value in that cycle and the new value from the next cycle.
REQ-026 Simultaneous wr_en and start SHALL both take effect.
REQ-027 Latency: the first valid select SHALL appear one cycle after start is sampled; an unpaused scan SHALL occupy LAST_SEL+1 SCAN cycles plus 1 DONE cycle.

Reset
REQ-028 While rst_n=0, independent of clk: FSM=IDLE, s=0, valid=0, busy=0, done=0, and a..h=RESET_VAL.
REQ-029 Reset asserted mid-scan SHALL abort the scan with no done pulse; after release, the block SHALL wait for a new start.
REQ-030 Deassertion of reset SHALL take effect at the first following rising clk edge; no output may change before that edge.

Verification
REQ-031 Reset, then write 0x1..0x8 to addr 0..7, pulse start: s SHALL step 0..7 over 8 cycles with valid=1, the mux SHALL read 1,2,…,8, and done SHALL pulse once on cycle 9.
REQ-032 hold=1 for 3 cycles when s=3: s SHALL stay at 3 for 4 cycles total, and done SHALL be delayed by 3 cycles.
REQ-033 start pulsed at s=5 during a scan: there SHALL be no restart and exactly one done.
REQ-034 Write 0xF to addr 2 while s=2: the mux SHALL output the old value that cycle; c SHALL read 0xF the following cycle.
REQ-035 rst_n dropped asynchronously at s=4: all outputs SHALL go to 0 immediately with no done pulse, and a subsequent start SHALL produce a full scan from s=0.
REQ-036 LAST_SEL=2 build with start held high: the select sequence SHALL be 0,1,2, then DONE, IDLE, then 0,1,2, repeating.

Source files
------------

// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - bus bundle for the mux scan sequencer
//
// Purpose: groups the register-write port, scan control inputs and all
// sequencer outputs so the design and its driver share one definition.
//
// Signals:
//   wr_en      register write strobe
//   wr_addr    register index to write (0=a .. 7=h)
//   wr_data    4-bit write data
//   start      scan request (only honoured when idle)
//   hold       pauses select advance while scanning
//   a .. h     data register outputs feeding the 8:1 mux data inputs
//   s          registered mux select
//   valid      s addresses a channel of the current scan
//   busy       sequencer is scanning or completing
//   done       one-cycle pulse at scan completion
//
// Modports:
//   master     drives writes and control, observes outputs
//   slave      the sequencer itself
interface mux_scan_sequencer_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       start;
    logic       hold;

    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] e;
    logic [3:0] f;
    logic [3:0] g;
    logic [3:0] h;
    logic [2:0] s;
    logic       valid;
    logic       busy;
    logic       done;

    modport master (
        output wr_en, wr_addr, wr_data, start, hold,
        input  a, b, c, d, e, f, g, h, s, valid, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, hold,
        output a, b, c, d, e, f, g, h, s, valid, busy, done
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - eight-register bank with a select scan sequencer for a 4-bit 8:1 mux
//
// Purpose: holds eight 4-bit data registers that feed an external 8:1 mux
// and steps the mux select from 0 up to LAST_SEL once per start request,
// with pause (hold), a one-cycle completion pulse and busy indication.
//
// Parameters:
//   LAST_SEL   final select value of a scan (0..7)
//   RESET_VAL  reset value of all eight data registers
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   bus        mux_scan_sequencer_if.slave: write port, start/hold,
//              register outputs a..h, select s, valid, busy, done
module mux_scan_sequencer #(
    parameter logic [2:0] LAST_SEL  = 3'd7,
    parameter logic [3:0] RESET_VAL = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_scan_sequencer_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] sel_q;
    logic [2:0] sel_d;
    logic [3:0] regs_q [8];

    // Register bank: writes land in any FSM state. A write to the channel
    // currently selected shows the old value this cycle and the new one
    // from the next, since the mux reads the register outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (bus.wr_en) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scan control. The select is forced to 0 outside SCAN so that IDLE and
    // DONE always present channel 0 with valid low. The increment is only
    // taken below LAST_SEL, so s cannot wrap from 7 back to 0 mid-scan.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                sel_d = 3'd0;
                if (bus.start) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!bus.hold) begin
                    if (sel_q == LAST_SEL) begin
                        state_d = ST_DONE;
                        sel_d   = 3'd0;
                    end else begin
                        sel_d = sel_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                // Start and hold are both ignored here; completion always
                // returns to IDLE so a held start sees one idle cycle.
                state_d = ST_IDLE;
                sel_d   = 3'd0;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.a = regs_q[0];
    assign bus.b = regs_q[1];
    assign bus.c = regs_q[2];
    assign bus.d = regs_q[3];
    assign bus.e = regs_q[4];
    assign bus.f = regs_q[5];
    assign bus.g = regs_q[6];
    assign bus.h = regs_q[7];

    assign bus.s     = sel_q;
    assign bus.valid = (state_q == ST_SCAN);
    assign bus.busy  = (state_q == ST_SCAN) || (state_q == ST_DONE);
    assign bus.done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard bench for mux_scan_sequencer (LAST_SEL=7 and LAST_SEL=2 builds)
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       drv_wr_en = 1'b0;
    logic [2:0] drv_wr_addr = 3'd0;
    logic [3:0] drv_wr_data = 4'd0;
    logic       drv_start = 1'b0;
    logic       drv_hold = 1'b0;

    always #5 clk = ~clk;

    mux_scan_sequencer_if ifc0 ();
    mux_scan_sequencer_if ifc1 ();

    assign ifc0.wr_en   = drv_wr_en;
    assign ifc0.wr_addr = drv_wr_addr;
    assign ifc0.wr_data = drv_wr_data;
    assign ifc0.start   = drv_start;
    assign ifc0.hold    = drv_hold;
    assign ifc1.wr_en   = drv_wr_en;
    assign ifc1.wr_addr = drv_wr_addr;
    assign ifc1.wr_data = drv_wr_data;
    assign ifc1.start   = drv_start;
    assign ifc1.hold    = drv_hold;

    mux_scan_sequencer #(.LAST_SEL(3'd7), .RESET_VAL(4'h0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc0.slave)
    );

    mux_scan_sequencer #(.LAST_SEL(3'd2), .RESET_VAL(4'h0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1.slave)
    );

    typedef struct {
        int          inst;
        logic [2:0]  s;
        logic        valid;
        logic        busy;
        logic        done;
        logic [3:0]  mux;
        logic [31:0] regs;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a scan is a position counter. -1 = idle,
    // 0..last = channel being presented, last+1 = completion cycle.
    int         m_phase [2];
    int         m_last  [2];
    logic [3:0] m_regs  [2][8];

    int n_total = 0;
    int n_pass  = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = -1;
            for (int r = 0; r < 8; r++) m_regs[k][r] = 4'h0;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.inst  = k;
            e.valid = (m_phase[k] >= 0) && (m_phase[k] <= m_last[k]);
            e.s     = e.valid ? 3'(m_phase[k]) : 3'd0;
            e.busy  = (m_phase[k] >= 0);
            e.done  = (m_phase[k] == m_last[k] + 1);
            e.mux   = m_regs[k][e.s];
            for (int r = 0; r < 8; r++) e.regs[r*4 +: 4] = m_regs[k][r];
            exp_q.push_back(e);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_phase[k] = -1;
                for (int r = 0; r < 8; r++) m_regs[k][r] = 4'h0;
            end else begin
                if (m_phase[k] < 0)
                    m_phase[k] = drv_start ? 0 : -1;
                else if (m_phase[k] <= m_last[k])
                    m_phase[k] = drv_hold ? m_phase[k] : m_phase[k] + 1;
                else
                    m_phase[k] = -1;
                if (drv_wr_en) m_regs[k][drv_wr_addr] = drv_wr_data;
            end
        end
    endtask

    // One clock: the model sees exactly the inputs the DUT samples at this
    // edge; new inputs are applied 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        push_expect();
        #2;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_until_phase(input int p);
        for (int k = 0; k < 20 && m_phase[0] != p; k++) tick();
    endtask

    task automatic wr(input logic [2:0] addr, input logic [3:0] data);
        drv_wr_en   = 1'b1;
        drv_wr_addr = addr;
        drv_wr_data = data;
        tick();
        drv_wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        drv_start = 1'b1;
        tick();
        drv_start = 1'b0;
    endtask

    // Drops reset between edges; the outputs must clear before any clock.
    task automatic async_reset();
        #1;
        model_reset();
        push_expect();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, inst, $time, act, req);
        else
            n_pass++;
    endtask

    // Monitor: after every clock edge and every asynchronous reset drop,
    // compare the DUT against all pending expectations.
    initial begin
        exp_t        e;
        logic [31:0] a_regs;
        logic [2:0]  a_s;
        logic        a_valid, a_busy, a_done;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.inst == 0) begin
                    a_regs  = {ifc0.h, ifc0.g, ifc0.f, ifc0.e, ifc0.d, ifc0.c, ifc0.b, ifc0.a};
                    a_s     = ifc0.s;
                    a_valid = ifc0.valid;
                    a_busy  = ifc0.busy;
                    a_done  = ifc0.done;
                end else begin
                    a_regs  = {ifc1.h, ifc1.g, ifc1.f, ifc1.e, ifc1.d, ifc1.c, ifc1.b, ifc1.a};
                    a_s     = ifc1.s;
                    a_valid = ifc1.valid;
                    a_busy  = ifc1.busy;
                    a_done  = ifc1.done;
                end
                chk("s",     e.inst, 32'(a_s),     32'(e.s));
                chk("valid", e.inst, 32'(a_valid), 32'(e.valid));
                chk("busy",  e.inst, 32'(a_busy),  32'(e.busy));
                chk("done",  e.inst, 32'(a_done),  32'(e.done));
                chk("mux",   e.inst, 32'(a_regs[a_s*4 +: 4]), 32'(e.mux));
                chk("regs",  e.inst, a_regs,       e.regs);
            end
        end
    end

    initial begin
        m_last[0] = 7;
        m_last[1] = 2;
        model_reset();

        // Reset state held across several edges.
        run(3);
        rst_n = 1'b1;
        run(2);

        // Load 1..8 and run one plain scan.
        for (int i = 0; i < 8; i++) wr(3'(i), 4'(i + 1));
        pulse_start();
        run(12);

        // Pause at s=3 for three cycles.
        pulse_start();
        run_until_phase(3);
        drv_hold = 1'b1;
        run(3);
        drv_hold = 1'b0;
        run(10);

        // Start while busy is ignored.
        pulse_start();
        run_until_phase(5);
        pulse_start();
        run(8);

        // Write to the channel currently selected.
        pulse_start();
        run_until_phase(2);
        wr(3'd2, 4'hF);
        run(8);

        // Asynchronous reset mid-scan, then a fresh scan.
        pulse_start();
        run_until_phase(4);
        async_reset();
        run(2);
        pulse_start();
        run(12);

        // Start held high: back-to-back scans.
        drv_start = 1'b1;
        run(30);
        drv_start = 1'b0;
        run(5);

        // Simultaneous write and start.
        drv_wr_en = 1'b1; drv_wr_addr = 3'd0; drv_wr_data = 4'hA;
        pulse_start();
        drv_wr_en = 1'b0;
        run(10);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            drv_wr_en   = 1'($urandom_range(0, 1));
            drv_wr_addr = 3'($urandom_range(0, 7));
            drv_wr_data = 4'($urandom_range(0, 15));
            drv_start   = ($urandom_range(0, 3) == 0);
            drv_hold    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) async_reset();
            else tick();
        end
        drv_start = 1'b0;
        drv_hold  = 1'b0;
        drv_wr_en = 1'b0;
        run(12);

        @(posedge clk);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
